fact_mmio_if: RTL and testbench
===============================

// Module: fact_mmio_if
// PURPOSE
//  Memory-mapped register front end for the factorial accelerator; sits upstream of the factorial control unit/datapath pair.
//  Holds operand n, issues a single-cycle go to the core, tracks busy/done/error/timeout and latches the result for bus reads.
//  Bus side is a simple synchronous-write, combinational-read slave port.
// PARAMETERS
//  DATA_W       32   bus data width and core result width
//  N_W          4    operand n width fed to the core
//  TIMEOUT_CYC  255  max BUSY cycles before a timeout is declared (>=2)
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  reset        in   1       asynchronous, active-high
//  we           in   1       bus write strobe, sampled at clk edge
//  addr         in   2       register select: 0 N, 1 GO, 2 STATUS, 3 RESULT
//  wdata        in   DATA_W  bus write data
//  rdata        out  DATA_W  bus read data, combinational from addr
//  core_n       out  N_W     operand to core, from N register
//  core_go      out  1       one-cycle start pulse to core
//  core_done    in   1       core done (may stay high several cycles)
//  core_error   in   1       core input-invalid / overflow indication
//  core_result  in   DATA_W  core product, valid while core_done=1
// BEHAVIOUR
//  - Reset: state=IDLE; N, RESULT, sticky done/err/timeout, watchdog all 0; core_go=0; rdata reflects zeros.
//  - Registers: N(0) RW, wdata[N_W-1:0], read zero-extended. GO(1) W: bit0=1 requests start; read returns {31'b0,busy}.
//    STATUS(2) RO: {28'b0, busy, timeout, err, done}. RESULT(3) RO. Writes to RO regs ignored.
//  - FSM IDLE/ISSUE/BUSY, registered outputs:
//    IDLE : we&&addr==1&&wdata[0] -> ISSUE; same edge clears done/err/timeout and watchdog.
//    ISSUE: core_go=1 for exactly this cycle -> BUSY unconditionally.
//    BUSY : core_error -> err=1, IDLE (RESULT unchanged); else core_done -> RESULT<=core_result, done=1, IDLE;
//           else watchdog==TIMEOUT_CYC-1 -> timeout=1, err=1, IDLE; else watchdog+1.
//  - busy = (state!=IDLE). core_go is 0 in IDLE and BUSY.
//  - Latency: GO write at edge k -> core_go high cycle k+1 -> earliest completion sampled edge k+3.
//  - Simultaneous core_error and core_done in BUSY: error wins, RESULT not updated.
//  - core_done/core_error outside BUSY ignored (covers core holding done across its final state).
//  - N write while busy ignored; core_n stable for whole operation. GO write while busy ignored.
//  - Sticky bits persist until next accepted GO; reading STATUS does not clear.
//  - Watchdog width = $clog2(TIMEOUT_CYC+1); never wraps (exits BUSY at limit).
//  - Reset mid-operation: immediate return to IDLE, core_go forced 0, all registers cleared.
// STRUCTURE
//  - fact_pkg: register address constants (ADDR_N/GO/STATUS/RESULT), STATUS bit indices, FSM state encodings.
//  - One sub-module: fact_watchdog (clear/enable/limit counter, asserts expired); rest is flat in this module.
// TESTING (bench uses behavioural core model; TIMEOUT_CYC=16 unless stated)
//  1. Write N=5, GO=1 -> core_go high exactly 1 cycle, core_n=5; model done with 120 -> RESULT=0x78, STATUS=0x1.
//  2. N=0 then N=1 runs -> RESULT=1 each, STATUS=0x1; second GO clears prior done until completion.
//  3. Model asserts core_error for N=13 -> STATUS=0x2, RESULT keeps previous 0x78.
//  4. Model never responds -> after 16 BUSY cycles STATUS=0x6 (timeout|err), busy=0; late core_done ignored.
//  5. During BUSY write N=9 and GO=1 -> core_n stays 5, no second core_go pulse, STATUS busy bit=1.
//  6. Assert reset 2 cycles into BUSY -> core_go=0, STATUS=0, RESULT=0, N=0; fresh GO afterwards completes normally.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared constants for the factorial accelerator register front end:
// bus register map, STATUS bit positions and the front-end FSM encoding.
package fact_pkg;

  localparam logic [1:0] ADDR_N      = 2'd0;
  localparam logic [1:0] ADDR_GO     = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  localparam int STAT_DONE    = 0;
  localparam int STAT_ERR     = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_BUSY    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

endpackage

// File: rtl/fact_watchdog.sv
// Saturating BUSY-cycle counter: clears on request, counts while enabled and
// flags expiry on the cycle the count reaches LIMIT-1 (it never wraps).
module fact_watchdog
  import fact_pkg::*;
#(
  parameter int LIMIT = 255,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  logic [CNT_W-1:0] r_count;

  assign o_expired = (r_count == CNT_W'(LIMIT - 1));

  // Counter holds at the limit so the FSM alone decides when to leave BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + 1'b1;
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/fact_mmio_if.sv
// Memory-mapped front end for the factorial core: holds operand N, issues a
// one-cycle go, tracks busy/done/error/timeout and latches the core result.
module fact_mmio_if
  import fact_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int N_W         = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [N_W-1:0]    core_n,
  output logic              core_go,
  input  logic              core_done,
  input  logic              core_error,
  input  logic [DATA_W-1:0] core_result
);

  state_t            r_state;
  logic [N_W-1:0]    r_n;
  logic [DATA_W-1:0] r_result;
  logic              r_done;
  logic              r_err;
  logic              r_timeout;
  logic              r_go;

  logic       w_busy;
  logic       w_accept;
  logic       w_wd_en;
  logic       w_wd_expired;
  logic [3:0] w_status;
  logic       w_unused_wdata;

  assign w_busy   = (r_state != ST_IDLE);
  assign w_accept = (r_state == ST_IDLE) && we && (addr == ADDR_GO) && wdata[0];
  assign w_wd_en  = (r_state == ST_BUSY) && !core_error && !core_done;
  assign w_unused_wdata = ^wdata[DATA_W-1:N_W];

  assign core_n  = r_n;
  assign core_go = r_go;

  fact_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_accept),
    .i_en      (w_wd_en),
    .o_expired (w_wd_expired)
  );

  // Operand register; frozen while an operation is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n <= '0;
    end else if (we && (addr == ADDR_N) && !w_busy) begin
      r_n <= wdata[N_W-1:0];
    end else begin
      r_n <= r_n;
    end
  end

  // Control FSM with registered go pulse, sticky status and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_go      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_ISSUE;
            r_go      <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
          end else begin
            r_go <= 1'b0;
          end
        end
        ST_ISSUE: begin
          r_go    <= 1'b0;
          r_state <= ST_BUSY;
        end
        ST_BUSY: begin
          r_go <= 1'b0;
          // Error outranks done: a faulted product must never reach RESULT.
          if (core_error) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else if (core_done) begin
            r_result <= core_result;
            r_done   <= 1'b1;
            r_state  <= ST_IDLE;
          end else if (w_wd_expired) begin
            r_timeout <= 1'b1;
            r_err     <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_state <= ST_BUSY;
          end
        end
        default: begin
          r_go    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // STATUS word assembly.
  always_comb begin
    w_status               = 4'd0;
    w_status[STAT_DONE]    = r_done;
    w_status[STAT_ERR]     = r_err;
    w_status[STAT_TIMEOUT] = r_timeout;
    w_status[STAT_BUSY]    = w_busy;
  end

  // Combinational read mux.
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_N:      rdata = DATA_W'(r_n);
      ADDR_GO:     rdata = DATA_W'(w_busy);
      ADDR_STATUS: rdata = DATA_W'(w_status);
      ADDR_RESULT: rdata = r_result;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_fact_mmio_if.sv
// Scoreboard bench for fact_mmio_if: directed bus traffic against a
// behavioural factorial core; reads and go pulses are checked by monitors.
module tb_fact_mmio_if;

  localparam int DATA_W = 32;
  localparam int N_W    = 4;
  localparam int TO_CYC = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              we;
  logic [1:0]        addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [N_W-1:0]    core_n;
  logic              core_go;
  logic              core_done;
  logic              core_error;
  logic [DATA_W-1:0] core_result;

  int          vec_cnt   = 0;
  int          miss_cnt  = 0;
  int          go_pulses = 0;
  int          model_lat = 1;
  logic        prev_go   = 1'b0;
  logic [3:0]  model_n;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [3:0]  n_q[$];
  event        rd_ev;

  always #5 clk = ~clk;

  fact_mmio_if #(
    .DATA_W      (DATA_W),
    .N_W         (N_W),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .core_n      (core_n),
    .core_go     (core_go),
    .core_done   (core_done),
    .core_error  (core_error),
    .core_result (core_result)
  );

  function automatic logic [31:0] fact(input logic [3:0] n);
    logic [31:0] p = 32'd1;
    for (int i = 2; i <= int'(n); i++) p = p * i;
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Read monitor: compares rdata with the next queued expectation.
  initial begin
    forever begin
      @(rd_ev);
      if (exp_q.size() == 0) begin
        chk("read_without_expectation", 32'(exp_q.size()), 32'd1);
      end else begin
        chk(name_q.pop_front(), rdata, exp_q.pop_front());
      end
    end
  end

  // Go monitor: single-cycle width and operand value at each pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (core_go === 1'b1) begin
        chk("go_one_cycle", 32'(prev_go), 32'd0);
        if (!prev_go) begin
          go_pulses++;
          if (n_q.size() == 0) chk("go_unexpected", 32'(n_q.size()), 32'd1);
          else chk("core_n_at_go", 32'(core_n), 32'(n_q.pop_front()));
        end
      end
      prev_go = core_go;
    end
  end

  // Behavioural core: answers model_lat edges after go, holds result 3 cycles.
  initial begin
    core_done = 1'b0; core_error = 1'b0; core_result = 32'd0;
    forever begin
      @(negedge clk);
      if (core_go === 1'b1) begin
        model_n = core_n;
        repeat (model_lat) @(posedge clk);
        #1;
        if (model_n >= 4'd13) core_error = 1'b1;
        else begin core_result = fact(model_n); core_done = 1'b1; end
        repeat (3) @(posedge clk);
        #1;
        core_done = 1'b0; core_error = 1'b0; core_result = 32'd0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; wdata = 32'd0;
  endtask

  task automatic issue_go(input logic [3:0] n_exp);
    n_q.push_back(n_exp);
    bus_write(2'd1, 32'd1);
  endtask

  task automatic bus_read(input string nm, input logic [1:0] a, input logic [31:0] e);
    addr = a;
    #1;
    name_q.push_back(nm);
    exp_q.push_back(e);
    -> rd_ev;
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    addr = 2'd2;
    @(negedge clk);
    while (rdata[3] && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (rdata[3]) chk({nm, "_idle_bound"}, rdata, 32'd0);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_core_go", 32'(core_go), 32'd0);
    bus_read("reset_n", 2'd0, 32'd0);
    bus_read("reset_go", 2'd1, 32'd0);
    @(negedge clk);
    bus_read("reset_status", 2'd2, 32'd0);
    bus_read("reset_result", 2'd3, 32'd0);
    reset = 1'b0;

    // T1: 5! = 120
    bus_write(2'd0, 32'd5);
    bus_read("t1_n", 2'd0, 32'd5);
    issue_go(4'd5);
    bus_read("t1_status_busy", 2'd2, 32'h8);
    bus_read("t1_go_read", 2'd1, 32'd1);
    wait_idle("t1");
    bus_read("t1_status", 2'd2, 32'h1);
    bus_read("t1_result", 2'd3, 32'h78);
    repeat (4) @(negedge clk);

    // T3: core error keeps previous RESULT
    bus_write(2'd0, 32'd13);
    issue_go(4'd13);
    wait_idle("t3");
    bus_read("t3_status", 2'd2, 32'h2);
    bus_read("t3_result", 2'd3, 32'h78);
    repeat (4) @(negedge clk);

    // T2: 0! and 1!
    bus_write(2'd0, 32'd0);
    issue_go(4'd0);
    bus_read("t2a_status_busy", 2'd2, 32'h8);
    wait_idle("t2a");
    bus_read("t2a_status", 2'd2, 32'h1);
    bus_read("t2a_result", 2'd3, 32'h1);
    repeat (4) @(negedge clk);
    bus_write(2'd0, 32'd1);
    issue_go(4'd1);
    bus_read("t2b_done_cleared", 2'd2, 32'h8);
    wait_idle("t2b");
    bus_read("t2b_status", 2'd2, 32'h1);
    bus_read("t2b_result", 2'd3, 32'h1);
    bus_write(2'd3, 32'hDEAD_BEEF);
    bus_write(2'd2, 32'h0000_000F);
    bus_read("ro_result_write", 2'd3, 32'h1);
    bus_read("ro_status_write", 2'd2, 32'h1);
    repeat (4) @(negedge clk);

    // T4: watchdog after 16 BUSY cycles; late done ignored
    model_lat = 20;
    bus_write(2'd0, 32'd3);
    issue_go(4'd3);
    repeat (16) @(negedge clk);
    bus_read("t4_busy_at_16", 2'd2, 32'h8);
    @(negedge clk);
    bus_read("t4_status_timeout", 2'd2, 32'h6);
    bus_read("t4_go_read", 2'd1, 32'd0);
    repeat (4) @(negedge clk);
    bus_read("t4_late_done_status", 2'd2, 32'h6);
    bus_read("t4_late_done_result", 2'd3, 32'h1);
    repeat (6) @(negedge clk);

    // T5: N and GO writes during BUSY are ignored
    model_lat = 6;
    bus_write(2'd0, 32'd5);
    issue_go(4'd5);
    @(negedge clk);
    bus_write(2'd0, 32'd9);
    bus_write(2'd1, 32'd1);
    chk("t5_core_n", 32'(core_n), 32'd5);
    bus_read("t5_n_reg", 2'd0, 32'd5);
    bus_read("t5_status_busy", 2'd2, 32'h8);
    wait_idle("t5");
    bus_read("t5_result", 2'd3, 32'h78);
    bus_read("t5_status", 2'd2, 32'h1);
    repeat (6) @(negedge clk);

    // T6: reset two cycles into BUSY, then a fresh run
    model_lat = 20;
    bus_write(2'd0, 32'd7);
    issue_go(4'd7);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_core_go", 32'(core_go), 32'd0);
    bus_read("t6_status", 2'd2, 32'd0);
    bus_read("t6_result", 2'd3, 32'd0);
    bus_read("t6_n", 2'd0, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    model_lat = 1;
    bus_write(2'd0, 32'd4);
    issue_go(4'd4);
    wait_idle("t6b");
    bus_read("t6b_result", 2'd3, 32'h18);
    bus_read("t6b_status", 2'd2, 32'h1);
    repeat (6) @(negedge clk);

    chk("go_pulse_count", 32'(go_pulses), 32'd8);
    chk("go_expect_left", 32'(n_q.size()), 32'd0);
    chk("read_expect_left", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
